// File: rtl/ssc_slave.sv
// ssc_slave: SSC frame slave (command, write and read data fields).
// Oversamples the async SSC lines on CLK and decodes one frame per sync-low window.
//
// Ports:
//   CLK, RESET            system clock, sync active-high reset
//   sscClk/sscSync        SSC clock (idle high) and frame sync (active low)
//   sscDataIn             serial data from master
//   sscDataOut/sscDataOE  serial read data and its drive enable
//   cmdOut/cmdValid       received command and its one-cycle strobe
//   cmdDir/cmdDataLength  per-command direction and data length
//   rdData                read payload, right-aligned
//   wrData/wrValid        write payload, right-aligned, and its strobe
//   busy/frameError       frame in progress / aborted-frame pulse
`timescale 1ns/1ps
module ssc_slave #(
  parameter int MAX_LEN = 48,
  parameter int CMD_LEN = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               sscClk,
  input  logic               sscSync,
  input  logic               sscDataIn,
  output logic               sscDataOut,
  output logic               sscDataOE,
  output logic [CMD_LEN-1:0] cmdOut,
  output logic               cmdValid,
  input  logic               cmdDir,
  input  logic [5:0]         cmdDataLength,
  input  logic [MAX_LEN-1:0] rdData,
  output logic [MAX_LEN-1:0] wrData,
  output logic               wrValid,
  output logic               busy,
  output logic               frameError
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WRITE,
    READ,
    WAIT_END
  } state_t;

  localparam logic [5:0] MAXL = 6'(MAX_LEN);
  localparam logic [5:0] CMDL = 6'(CMD_LEN);

  state_t state;

  logic [2:0] clkS;
  logic [1:0] syncS;
  logic [1:0] dataS;
  logic [1:0] warm;
  logic       armed;

  logic [5:0] bitCnt;
  logic [5:0] len;
  logic [MAX_LEN-2:0] shiftReg;
  logic [MAX_LEN-1:0] rdReg;

  logic rise;
  logic fall;
  logic syncHi;
  logic bitIn;
  logic [5:0] lenC;
  logic [5:0] cntNext;
  logic [5:0] rdIdx;
  logic [MAX_LEN-1:0] shiftNext;

  always_comb begin
    rise      = clkS[1] & ~clkS[2];
    fall      = ~clkS[1] & clkS[2];
    syncHi    = syncS[1];
    bitIn     = dataS[1];
    lenC      = (cmdDataLength > MAXL) ? MAXL : cmdDataLength;
    cntNext   = bitCnt + 6'd1;
    rdIdx     = len - bitCnt - 6'd1;
    shiftNext = {shiftReg, bitIn};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      clkS       <= 3'b111;
      syncS      <= 2'b11;
      dataS      <= 2'b00;
      warm       <= 2'd0;
      armed      <= 1'b0;
      bitCnt     <= 6'd0;
      len        <= 6'd0;
      shiftReg   <= '0;
      rdReg      <= '0;
      cmdOut     <= '0;
      cmdValid   <= 1'b0;
      wrData     <= '0;
      wrValid    <= 1'b0;
      busy       <= 1'b0;
      frameError <= 1'b0;
      sscDataOE  <= 1'b0;
      sscDataOut <= 1'b1;
    end else begin
      clkS  <= {clkS[1:0], sscClk};
      syncS <= {syncS[0], sscSync};
      dataS <= {dataS[0], sscDataIn};
      // The sync pipeline only reflects the pin two cycles after
      // reset; arming before that would trust the reset value.
      if (!warm[1]) warm <= warm + 2'd1;
      cmdValid   <= 1'b0;
      wrValid    <= 1'b0;
      frameError <= 1'b0;
      unique case (state)
        IDLE: begin
          if (syncHi) begin
            if (warm[1]) armed <= 1'b1;
          end else if (armed) begin
            state    <= CMD;
            busy     <= 1'b1;
            bitCnt   <= 6'd0;
            shiftReg <= '0;
            armed    <= 1'b0;
          end
        end
        CMD: begin
          if (cmdValid) begin
            // Decode cycle: direction/length/payload are valid now.
            rdReg    <= rdData;
            len      <= lenC;
            bitCnt   <= 6'd0;
            shiftReg <= '0;
            if (lenC == 6'd0) begin
              state <= WAIT_END;
            end else if (cmdDir) begin
              state <= WRITE;
            end else begin
              state      <= READ;
              sscDataOE  <= 1'b1;
              sscDataOut <= rdData[lenC - 6'd1];
            end
          end else if (syncHi) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frameError <= 1'b1;
            armed      <= 1'b1;
          end else if (rise) begin
            shiftReg <= shiftNext[MAX_LEN-2:0];
            bitCnt   <= cntNext;
            if (cntNext == CMDL) begin
              cmdOut   <= shiftNext[CMD_LEN-1:0];
              cmdValid <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (syncHi) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frameError <= 1'b1;
            armed      <= 1'b1;
          end else if (rise) begin
            shiftReg <= shiftNext[MAX_LEN-2:0];
            bitCnt   <= cntNext;
            if (cntNext == len) begin
              wrData  <= shiftNext;
              wrValid <= 1'b1;
              state   <= WAIT_END;
            end
          end
        end
        READ: begin
          if (syncHi) begin
            sscDataOE  <= 1'b0;
            sscDataOut <= 1'b1;
            if (bitCnt == len) begin
              state <= WAIT_END;
            end else begin
              state      <= IDLE;
              busy       <= 1'b0;
              frameError <= 1'b1;
              armed      <= 1'b1;
            end
          end else if (rise && bitCnt != len) begin
            bitCnt <= cntNext;
          end else if (fall) begin
            if (bitCnt == len) begin
              sscDataOE  <= 1'b0;
              sscDataOut <= 1'b1;
              state      <= WAIT_END;
            end else begin
              sscDataOut <= rdReg[rdIdx];
            end
          end
        end
        WAIT_END: begin
          if (syncHi) begin
            state <= IDLE;
            busy  <= 1'b0;
            armed <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ssc_slave.sv
// tb_ssc_slave: directed frames driven by a bit-level SSC master model.
// Expected commands/payloads are queued at drive time and matched on DUT strobes.
`timescale 1ns/1ps
module tb_ssc_slave;

  localparam int MAX_LEN = 48;
  localparam int CMD_LEN = 5;
  localparam int HALF = 6;

  logic CLK = 1'b0;
  logic RESET;
  logic sscClk;
  logic sscSync;
  logic sscDataIn;
  logic sscDataOut;
  logic sscDataOE;
  logic [CMD_LEN-1:0] cmdOut;
  logic cmdValid;
  logic cmdDir;
  logic [5:0] cmdDataLength;
  logic [MAX_LEN-1:0] rdData;
  logic [MAX_LEN-1:0] wrData;
  logic wrValid;
  logic busy;
  logic frameError;

  always #5 CLK = ~CLK;

  ssc_slave #(.MAX_LEN(MAX_LEN), .CMD_LEN(CMD_LEN)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .sscClk(sscClk),
    .sscSync(sscSync),
    .sscDataIn(sscDataIn),
    .sscDataOut(sscDataOut),
    .sscDataOE(sscDataOE),
    .cmdOut(cmdOut),
    .cmdValid(cmdValid),
    .cmdDir(cmdDir),
    .cmdDataLength(cmdDataLength),
    .rdData(rdData),
    .wrData(wrData),
    .wrValid(wrValid),
    .busy(busy),
    .frameError(frameError)
  );

  // Command decoder the slave's host would provide.
  always_comb begin
    cmdDir        = 1'b0;
    cmdDataLength = 6'd0;
    rdData        = '0;
    case (cmdOut)
      5'h16: begin cmdDir = 1'b1; cmdDataLength = 6'd12; end
      5'h03: begin cmdDataLength = 6'd8; rdData = 48'h3C; end
      5'h0A: begin cmdDir = 1'b1; cmdDataLength = 6'd63; end
      5'h05: begin cmdDir = 1'b1; cmdDataLength = 6'd4; end
      5'h11: begin cmdDataLength = 6'd16; rdData = 48'hBEEF; end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;
  int feCnt = 0;
  int oeCnt = 0;
  logic [CMD_LEN-1:0] cmdQ[$];
  logic [CMD_LEN-1:0] cmdGot[$];
  logic [MAX_LEN-1:0] wrQ[$];
  logic [MAX_LEN-1:0] wrGot[$];
  logic [7:0] rdQ[$];

  always @(negedge CLK) begin
    if (cmdValid) cmdGot.push_back(cmdOut);
    if (wrValid) wrGot.push_back(wrData);
    if (frameError) feCnt++;
    if (sscDataOE) oeCnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic sscBit(input logic b, output logic smp, output logic oe);
    sscClk = 1'b0;
    sscDataIn = b;
    tick(HALF - 1);
    smp = sscDataOut;
    oe = sscDataOE;
    tick(1);
    sscClk = 1'b1;
    tick(HALF);
  endtask

  task automatic frameBits(input logic [4:0] cmd, input logic [63:0] data,
                           input int n, output logic [63:0] rd,
                           output logic oeCmd, output logic oeData);
    logic s;
    logic o;
    rd = '0;
    oeCmd = 1'b0;
    oeData = 1'b1;
    sscSync = 1'b0;
    tick(6);
    for (int i = CMD_LEN - 1; i >= 0; i--) begin
      sscBit(cmd[i], s, o);
      oeCmd |= o;
    end
    for (int i = n - 1; i >= 0; i--) begin
      sscBit(data[i], s, o);
      rd = {rd[62:0], s};
      oeData &= o;
    end
  endtask

  task automatic endFrame(output int lat);
    sscSync = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      lat++;
      if (!busy) break;
    end
    tick(4);
  endtask

  task automatic scoreboard(input string tag);
    check({tag, "_cmdCount"}, 64'(cmdGot.size()), 64'(cmdQ.size()));
    while (cmdGot.size() > 0 && cmdQ.size() > 0)
      check({tag, "_cmdOut"}, 64'(cmdGot.pop_front()), 64'(cmdQ.pop_front()));
    check({tag, "_wrCount"}, 64'(wrGot.size()), 64'(wrQ.size()));
    while (wrGot.size() > 0 && wrQ.size() > 0)
      check({tag, "_wrData"}, 64'(wrGot.pop_front()), 64'(wrQ.pop_front()));
    cmdGot.delete();
    cmdQ.delete();
    wrGot.delete();
    wrQ.delete();
  endtask

  initial begin
    logic [63:0] rd;
    logic oeC;
    logic oeD;
    int lat;
    int feBefore;
    int oeBefore;
    logic s;
    logic o;

    RESET = 1'b1;
    sscClk = 1'b1;
    sscSync = 1'b1;
    sscDataIn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_oe", 64'(sscDataOE), 64'd0);
    check("rst_out", 64'(sscDataOut), 64'd1);
    check("rst_cmdOut", 64'(cmdOut), 64'd0);
    check("rst_wrData", 64'(wrData), 64'd0);
    check("rst_strobes", 64'({cmdValid, wrValid, frameError}), 64'd0);
    tick(1);
    RESET = 1'b0;
    tick(6);

    // Write frame, 12 bits.
    cmdQ.push_back(5'h16);
    wrQ.push_back(48'hA5C);
    frameBits(5'h16, 64'hA5C, 12, rd, oeC, oeD);
    endFrame(lat);
    check("wr_busyLat", 64'(lat >= 2 && lat <= 3), 64'd1);
    check("wr_oeCmd", 64'(oeC), 64'd0);
    check("wr_wrData", 64'(wrData), 64'hA5C);
    scoreboard("wr");

    // Read frame, 8 bits.
    cmdQ.push_back(5'h03);
    rdQ.push_back(8'h3C);
    frameBits(5'h03, 64'h0, 8, rd, oeC, oeD);
    check("rd_data", 64'(rd[7:0]), 64'(rdQ.pop_front()));
    check("rd_oeCmd", 64'(oeC), 64'd0);
    check("rd_oeData", 64'(oeD), 64'd1);
    endFrame(lat);
    check("rd_oeEnd", 64'(sscDataOE), 64'd0);
    check("rd_outEnd", 64'(sscDataOut), 64'd1);
    scoreboard("rd");

    // Zero length, extra clocks in WAIT_END must be ignored.
    oeBefore = oeCnt;
    cmdQ.push_back(5'h1F);
    frameBits(5'h1F, 64'h0, 0, rd, oeC, oeD);
    for (int i = 0; i < 3; i++) sscBit(1'b1, s, o);
    endFrame(lat);
    check("zero_busyLat", 64'(lat >= 2 && lat <= 3), 64'd1);
    check("zero_oe", 64'(oeCnt - oeBefore), 64'd0);
    scoreboard("zero");

    // Abort after 7 of 12 write bits.
    feBefore = feCnt;
    cmdQ.push_back(5'h16);
    frameBits(5'h16, 64'h55, 7, rd, oeC, oeD);
    sscSync = 1'b1;
    tick(8);
    check("abort_fe", 64'(feCnt - feBefore), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_wrData", 64'(wrData), 64'hA5C);
    scoreboard("abort");

    // Clamped 63 -> 48 bit write, then back-to-back frame.
    cmdQ.push_back(5'h0A);
    wrQ.push_back(48'hFFFF_FFFF_FFFF);
    frameBits(5'h0A, 64'hFFFF_FFFF_FFFF, 48, rd, oeC, oeD);
    sscSync = 1'b1;
    tick(4);
    cmdQ.push_back(5'h05);
    wrQ.push_back(48'h9);
    frameBits(5'h05, 64'h9, 4, rd, oeC, oeD);
    endFrame(lat);
    check("b2b_wrData", 64'(wrData), 64'h9);
    scoreboard("b2b");

    // Reset in the middle of read bit 4.
    feBefore = feCnt;
    cmdQ.push_back(5'h11);
    frameBits(5'h11, 64'h0, 3, rd, oeC, oeD);
    check("rr_prefix", 64'(rd[2:0]), 64'h5);
    sscClk = 1'b0;
    tick(2);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("rr_oe", 64'(sscDataOE), 64'd0);
    check("rr_out", 64'(sscDataOut), 64'd1);
    tick(1);
    RESET = 1'b0;
    tick(2);
    sscClk = 1'b1;
    tick(HALF);
    // Sync still low: these clocks must not start a frame.
    for (int i = 0; i < 5; i++) sscBit(1'b1, s, o);
    tick(6);
    check("rr_busyIgnored", 64'(busy), 64'd0);
    check("rr_fe", 64'(feCnt - feBefore), 64'd0);
    scoreboard("rr");
    sscSync = 1'b1;
    tick(6);
    cmdQ.push_back(5'h05);
    wrQ.push_back(48'h6);
    frameBits(5'h05, 64'h6, 4, rd, oeC, oeD);
    endFrame(lat);
    check("post_busyLat", 64'(lat >= 2 && lat <= 3), 64'd1);
    check("post_wrData", 64'(wrData), 64'h6);
    scoreboard("post");
    check("total_fe", 64'(feCnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
